// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with a valid/ready request/response handshake and fixed wait states
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_we, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        w_accept, w_access, w_we, w_err, w_wr;
  logic [31:0] w_addr, w_wdata;
  logic [AW-1:0] w_idx;
  // With zero wait states the access happens on the accept edge, so the live inputs are used in IDLE
  assign w_accept  = r_state == IDLE && req_valid;
  assign w_we      = r_state == IDLE ? req_we    : r_we;
  assign w_addr    = r_state == IDLE ? req_addr  : r_addr;
  assign w_wdata   = r_state == IDLE ? req_wdata : r_wdata;
  assign w_idx     = w_addr[AW+1:2];
  assign w_err     = |w_addr[1:0] || {2'b0, w_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_wr      = w_access && w_we && !w_err && !rst;
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign busy      = r_state != IDLE;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  // Next state, wait counter and the single-cycle access strobe
  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_access = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        if (WAIT_CYCLES == 0) begin
          w_next   = RESP;
          w_access = 1'b1;
        end else begin
          w_next = WAIT;
          w_cnt  = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        w_cnt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next   = RESP;
          w_access = 1'b1;
        end
      end
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Control state, latched request and response registers; reset aborts any pending access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_idx];
      end
    end
  end
  // Backing storage is never cleared; writes are suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= w_wdata;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The parameter DEPTH_WORDS SHALL default to 1024 and set the number of 32-bit words of backing storage.
REQ-002 The parameter WAIT_CYCLES SHALL default to 2 and set the wait states between request acceptance and memory access; legal range is 0..15.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  initiator (MEM stage) presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  MemRW encoding: 1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address (ALU result).
REQ-009 req_wdata  input  32  store data (rs2 value).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator consumes the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-017 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; req_we, req_addr and req_wdata SHALL be latched on that edge and ignored afterwards.
REQ-018 When WAIT_CYCLES is 0, the memory access SHALL occur on the accept edge and the FSM SHALL enter RESP.
REQ-019 When WAIT_CYCLES is nonzero, the FSM SHALL enter WAIT with a counter loaded with WAIT_CYCLES on the accept edge.
REQ-020 In WAIT the counter SHALL decrement by 1 each cycle; on the edge where it equals 1, the access SHALL occur and the FSM SHALL enter RESP.
REQ-021 For a request accepted in cycle T, rsp_valid SHALL first be 1 in cycle T+1+WAIT_CYCLES.
REQ-022 The word index SHALL be the latched req_addr[31:2]; a request is an error if req_addr[1:0] is nonzero or the index is >= DEPTH_WORDS.
REQ-023 A non-error store SHALL write req_wdata to the indexed word at the access edge; its response SHALL carry rsp_rdata = 0 and rsp_err = 0.
REQ-024 A non-error load SHALL return the indexed word as it stood at the access edge, with rsp_err = 0.
REQ-025 An error request SHALL NOT modify memory, and its response SHALL carry rsp_err = 1 and rsp_rdata = 0.
REQ-026 In RESP, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is 1; on that edge the FSM SHALL return to IDLE.
REQ-027 No request SHALL be accepted in the RESP cycle in which rsp_ready is 1; the next acceptance is possible in the following IDLE cycle at the earliest.
REQ-028 A store followed by a load to the same address SHALL return the stored value (read-after-write ordering).
REQ-029 Changes on the req_* inputs while in WAIT or RESP SHALL have no effect.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and busy 0, which puts req_ready at 1.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 A store whose access edge has not yet occurred when rst asserts SHALL NOT be committed.
REQ-033 After rst deasserts, the first request SHALL be accepted on the first rising edge with req_valid = 1.

Verification (WAIT_CYCLES = 2, DEPTH_WORDS = 1024)
REQ-034 Store addr 0x10 data 0xDEADBEEF accepted in cycle T, then load 0x10 -> rsp_valid in T+3, rsp_err 0; the load returns 0xDEADBEEF.
REQ-035 Load addr 0x12 (misaligned) -> rsp_err 1, rsp_rdata 0; a subsequent load of 0x10 still returns the prior value.
REQ-036 Store addr 0x1000 (index 1024) -> rsp_err 1; memory is unchanged, checked by reading back word 0x0FFC.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready stays 0; rsp_ready = 1 -> IDLE on the next cycle.
REQ-038 Store addr 0x20 data 0x1 with rst asserted in the first WAIT cycle -> outputs cleared asynchronously, and a later load of 0x20 returns the pre-test value, not 0x1.
REQ-039 Back-to-back requests with rsp_ready tied to 1 -> one response every 4 cycles, and req_addr toggling during WAIT does not alter the response.
